pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline hazard and flush controller. It generates the stall, bubble and flush controls consumed by the PC register, the IF/ID register and the ID/EX register (`id_lw`, `id_flush`, `ctrl`). It detects load-use hazards, waits on a busy multiply/divide unit, squashes wrong-path fetches on a taken branch, and sequences a multi-cycle flush on exceptions and `eret`. It sits beside the ID stage and takes its inputs from the ID decode, the ID/EX outputs and the EX stage.

## Interface
Parameters:
- `EXC_FLUSH_CYCLES`, default 2: number of cycles flush is held after an exception or `eret` (legal range 1–15).
- `REG_W`, default 5: register index width.

Ports:
- `clk`  in  1  Pipeline clock. One clock domain; all state updates on the rising edge.
- `reset`  in  1  Asynchronous, active-high reset.
- `id_rs`, `id_rt`  in  5  Source register indices of the instruction in ID.
- `id_use_rs`, `id_use_rt`  in  1  The ID instruction actually reads rs / rt.
- `id_use_hilo`  in  1  The ID instruction reads HI/LO or issues a mult/div.
- `ex_memread`  in  3  `MemRead` of the instruction in EX; nonzero means a load.
- `ex_rt`  in  5  Destination `rt` of the instruction in EX.
- `ex_branch_taken`  in  1  The EX branch or jump resolved as taken.
- `mdu_busy`  in  1  The multiply/divide unit is still computing.
- `exc_req`  in  1  Exception or `eret` accepted this cycle; the PC is redirected by the CP0 logic.
- `pc_stall`  out  1  Hold the PC.
- `if_id_stall`  out  1  Hold the IF/ID register.
- `if_id_flush`  out  1  Clear the IF/ID register.
- `id_lw`  out  1  Insert a bubble into ID/EX (load-use or MDU stall).
- `id_flush`  out  1  Clear the ID/EX register.
- `ctrl`  out  1  Suppress `RegWrite` of the instruction entering EX.

## Operation
Hazard conditions (combinational):
- `lu_hit` = (`ex_memread` != 0) && (`ex_rt` != 0) && ((`id_use_rs` && `id_rs` == `ex_rt`) || (`id_use_rt` && `id_rt` == `ex_rt`)).
- `mdu_hit` = `mdu_busy` && `id_use_hilo`.

Priority, highest first: `exc_req` > `ex_branch_taken` > `mdu_hit` > `lu_hit`.

The state machine is registered. The outputs are a Mealy function of the current state and the current inputs, so they take effect at the same edge that the downstream registers sample.

States and transitions:
- **RUN**
  - On `exc_req`: assert `if_id_flush`, `id_flush`, `ctrl`; load `flush_cnt` = `EXC_FLUSH_CYCLES`-1; go to EXC_FLUSH. If `EXC_FLUSH_CYCLES` = 1, stay in RUN.
  - On `ex_branch_taken`: assert `if_id_flush` and `id_flush` for one cycle; stay in RUN.
  - On `mdu_hit`: assert `pc_stall`, `if_id_stall`, `id_lw`; go to MDU_WAIT.
  - On `lu_hit`: assert `pc_stall`, `if_id_stall`, `id_lw`; go to LU_STALL.
- **LU_STALL**
  - Exactly one bubble has been inserted; no stall outputs are asserted.
  - Return to RUN unconditionally.
  - `exc_req` or a taken branch in this cycle is handled as in RUN.
  - `lu_hit` is ignored in this state, so there is never a double stall for the same load.
- **MDU_WAIT**
  - While `mdu_hit` is true: keep `pc_stall`, `if_id_stall`, `id_lw` asserted.
  - When `mdu_busy` falls: deassert all outputs and go to RUN.
  - `exc_req` preempts: handled as in RUN.
- **EXC_FLUSH**
  - Assert `if_id_flush`, `id_flush`, `ctrl` every cycle.
  - While `flush_cnt` != 0: decrement. When `flush_cnt` reaches 0: go to RUN.
  - A new `exc_req` reloads `flush_cnt` = `EXC_FLUSH_CYCLES`-1.
  - All stall outputs are forced to 0 in this state.

Boundary rules:
- Flush and stall are never asserted together. When flush wins, `pc_stall` = 0 so that the redirect lands.
- `ex_rt` = 0 never causes a stall.
- `flush_cnt` is 4 bits wide and never wraps.

## Timing
- While `reset` is high: state = RUN, `flush_cnt` = 0, and every output is held at 0.
- Reset is asynchronous assert and synchronous deassert (release is synchronised upstream).
- Load-use bubble: 1 cycle from `lu_hit` to the next RUN.
- MDU stall: lasts as long as `mdu_busy` is high.
- Exception flush: exactly `EXC_FLUSH_CYCLES` cycles, counting the `exc_req` cycle.
- Reset asserted mid-flush or mid-stall aborts immediately to RUN with all outputs at 0.

## Configuration
- `PIPE_HAZARD_STATS_EN`, when defined, adds the following ports:
  - `stall_count` out 32: cycles with `pc_stall` = 1.
  - `flush_count` out 32: cycles with `id_flush` = 1.
- Both counters are free-running, wrap modulo 2^32, and reset to 0.
- When the macro is undefined, these ports and counters do not exist and the rest of the behaviour is identical.

## Structure
- Shared package `pipe_ctrl_pkg` holds:
  - the state enum (RUN, LU_STALL, MDU_WAIT, EXC_FLUSH);
  - the `MemRead` "no load" constant 3'b000;
  - the register-index width.
- One sub-module, `hazard_detect`: the combinational `lu_hit` / `mdu_hit` compare.
- The FSM, the flush counter and the optional stats counters live in `pipe_hazard_ctrl`.

## Test plan
- Load-use: `ex_memread`=3'b001, `ex_rt`=8, `id_rs`=8, `id_use_rs`=1 → one cycle of `pc_stall`/`if_id_stall`/`id_lw`=1, then all 0; no second stall.
- Zero register: `ex_memread`=3'b001, `ex_rt`=0, `id_rt`=0, `id_use_rt`=1 → no stall.
- MDU: `mdu_busy` high for 5 cycles with `id_use_hilo`=1 → `id_lw`=1 for 5 cycles, released the cycle `mdu_busy` falls.
- Exception with `EXC_FLUSH_CYCLES`=2:
  - `exc_req` pulse → `id_flush`/`if_id_flush`/`ctrl`=1 for exactly 2 cycles, with `pc_stall`=0 throughout.
  - A second `exc_req` in the 2nd cycle → flush extends 1 further cycle.
- Priority: `lu_hit` and `ex_branch_taken` in the same cycle → flush only, `pc_stall`=0, state remains RUN.
- Reset in MDU_WAIT → all outputs 0 immediately; with `PIPE_HAZARD_STATS_EN` defined, `stall_count`=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/flush controller.
package pipe_ctrl_pkg;

    localparam int unsigned RegW      = 5;
    localparam int unsigned FlushCntW = 4;
    localparam logic [2:0]  MemNoLoad = 3'b000;

    typedef enum logic [1:0] {
        StRun,
        StLuStall,
        StMduWait,
        StExcFlush
    } state_e;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use and busy-MDU hazard compare for the instruction in ID.
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_W = RegW
) (
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             id_use_rs_i,
    input  logic             id_use_rt_i,
    input  logic             id_use_hilo_i,
    input  logic [2:0]       ex_memread_i,
    input  logic [REG_W-1:0] ex_rt_i,
    input  logic             mdu_busy_i,
    output logic             lu_hit_o,
    output logic             mdu_hit_o
);

    always_comb begin
        // A load targeting r0 never produces a value worth waiting for.
        lu_hit_o  = (ex_memread_i != MemNoLoad) && (ex_rt_i != '0) &&
                    ((id_use_rs_i && (id_rs_i == ex_rt_i)) ||
                     (id_use_rt_i && (id_rt_i == ex_rt_i)));
        mdu_hit_o = mdu_busy_i && id_use_hilo_i;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/bubble/flush sequencer for PC, IF/ID and ID/EX registers.
// Optional PIPE_HAZARD_STATS_EN adds stall_count/flush_count cycle counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned EXC_FLUSH_CYCLES = 2,
    parameter int unsigned REG_W            = RegW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_use_hilo,
    input  logic [2:0]       ex_memread,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_branch_taken,
    input  logic             mdu_busy,
    input  logic             exc_req,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_lw,
    output logic             id_flush,
    output logic             ctrl
`ifdef PIPE_HAZARD_STATS_EN
    ,
    output logic [31:0]      stall_count,
    output logic [31:0]      flush_count
`endif
);

    localparam logic [FlushCntW-1:0] FlushReload = FlushCntW'(EXC_FLUSH_CYCLES - 1);

    state_e               state_q, state_d;
    logic [FlushCntW-1:0] flush_cnt_q, flush_cnt_d;
    logic                 lu_hit, mdu_hit;
    logic                 stall_c, if_flush_c, id_flush_c, ctrl_c;

    hazard_detect #(
        .REG_W(REG_W)
    ) u_hazard_detect (
        .id_rs_i      (id_rs),
        .id_rt_i      (id_rt),
        .id_use_rs_i  (id_use_rs),
        .id_use_rt_i  (id_use_rt),
        .id_use_hilo_i(id_use_hilo),
        .ex_memread_i (ex_memread),
        .ex_rt_i      (ex_rt),
        .mdu_busy_i   (mdu_busy),
        .lu_hit_o     (lu_hit),
        .mdu_hit_o    (mdu_hit)
    );

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        stall_c     = 1'b0;
        if_flush_c  = 1'b0;
        id_flush_c  = 1'b0;
        ctrl_c      = 1'b0;

        if (state_q == StExcFlush) begin
            if_flush_c = 1'b1;
            id_flush_c = 1'b1;
            ctrl_c     = 1'b1;
            if (exc_req) begin
                flush_cnt_d = FlushReload;
                state_d     = (FlushReload != '0) ? StExcFlush : StRun;
            end else if (flush_cnt_q > 1) begin
                flush_cnt_d = flush_cnt_q - 1'b1;
            end else begin
                flush_cnt_d = '0;
                state_d     = StRun;
            end
        end else if (exc_req) begin
            if_flush_c  = 1'b1;
            id_flush_c  = 1'b1;
            ctrl_c      = 1'b1;
            flush_cnt_d = FlushReload;
            state_d     = (FlushReload != '0) ? StExcFlush : StRun;
        end else if (ex_branch_taken) begin
            if_flush_c = 1'b1;
            id_flush_c = 1'b1;
            state_d    = StRun;
        end else begin
            case (state_q)
                StRun: begin
                    if (mdu_hit) begin
                        stall_c = 1'b1;
                        state_d = StMduWait;
                    end else if (lu_hit) begin
                        stall_c = 1'b1;
                        state_d = StLuStall;
                    end
                end
                StMduWait: begin
                    stall_c = mdu_hit;
                    state_d = mdu_hit ? StMduWait : StRun;
                end
                // The bubble is already in ID/EX; the same load must not stall twice.
                default: state_d = StRun;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StRun;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Outputs are gated so they read 0 for the whole time reset is high.
    always_comb begin
        pc_stall    = stall_c & ~reset;
        if_id_stall = stall_c & ~reset;
        id_lw       = stall_c & ~reset;
        if_id_flush = if_flush_c & ~reset;
        id_flush    = id_flush_c & ~reset;
        ctrl        = ctrl_c & ~reset;
    end

`ifdef PIPE_HAZARD_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (pc_stall) stall_count <= stall_count + 32'd1;
            if (id_flush) flush_count <= flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized run vs. a model.
module tb_pipe_hazard_ctrl;

    localparam int N = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_use_rs, id_use_rt, id_use_hilo;
    logic [2:0] ex_memread;
    logic       ex_branch_taken, mdu_busy, exc_req;
    logic       pc_stall, if_id_stall, if_id_flush, id_lw, id_flush, ctrl;
`ifdef PIPE_HAZARD_STATS_EN
    logic [31:0] stall_count, flush_count;
`endif

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .EXC_FLUSH_CYCLES(N),
        .REG_W           (5)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_use_rs      (id_use_rs),
        .id_use_rt      (id_use_rt),
        .id_use_hilo    (id_use_hilo),
        .ex_memread     (ex_memread),
        .ex_rt          (ex_rt),
        .ex_branch_taken(ex_branch_taken),
        .mdu_busy       (mdu_busy),
        .exc_req        (exc_req),
        .pc_stall       (pc_stall),
        .if_id_stall    (if_id_stall),
        .if_id_flush    (if_id_flush),
        .id_lw          (id_lw),
        .id_flush       (id_flush),
        .ctrl           (ctrl)
`ifdef PIPE_HAZARD_STATS_EN
        ,
        .stall_count    (stall_count),
        .flush_count    (flush_count)
`endif
    );

    // {pc_stall, if_id_stall, if_id_flush, id_lw, id_flush, ctrl}
    localparam logic [5:0] OStall = 6'b110100;
    localparam logic [5:0] OExc   = 6'b001011;
    localparam logic [5:0] OBr    = 6'b001010;
    localparam logic [5:0] ONone  = 6'b000000;

    logic [5:0] outs;
    assign outs = {pc_stall, if_id_stall, if_id_flush, id_lw, id_flush, ctrl};

    int checks = 0;
    int errors = 0;

    // Behavioural model: remaining flush cycles, "bubble just inserted", "waiting on MDU".
    int          m_flush_left, n_flush_left;
    bit          m_bubble, n_bubble, m_mdu, n_mdu;
    logic [31:0] m_stall_cnt, m_flush_cnt;
    logic [5:0]  e;

    function automatic void model_clear();
        m_flush_left = 0;
        m_bubble     = 1'b0;
        m_mdu        = 1'b0;
        m_stall_cnt  = 32'd0;
        m_flush_cnt  = 32'd0;
    endfunction

    function automatic void model_eval();
        bit lu, mh;
        lu = (ex_memread != 3'b000) && (ex_rt != 5'd0) &&
             ((id_use_rs && id_rs == ex_rt) || (id_use_rt && id_rt == ex_rt));
        mh = mdu_busy && id_use_hilo;
        e            = ONone;
        n_flush_left = 0;
        n_bubble     = 1'b0;
        n_mdu        = 1'b0;
        if (reset) return;
        if (m_flush_left > 0 || exc_req) begin
            e            = OExc;
            n_flush_left = exc_req ? N - 1 : m_flush_left - 1;
        end else if (ex_branch_taken) begin
            e = OBr;
        end else if (m_mdu) begin
            if (mh) begin
                e     = OStall;
                n_mdu = 1'b1;
            end
        end else if (!m_bubble) begin
            if (mh) begin
                e     = OStall;
                n_mdu = 1'b1;
            end else if (lu) begin
                e        = OStall;
                n_bubble = 1'b1;
            end
        end
    endfunction

    task automatic tick();
        model_eval();
        @(posedge clk);
        if (reset) begin
            model_clear();
        end else begin
            m_flush_left = n_flush_left;
            m_bubble     = n_bubble;
            m_mdu        = n_mdu;
            if (e[5]) m_stall_cnt = m_stall_cnt + 32'd1;
            if (e[1]) m_flush_cnt = m_flush_cnt + 32'd1;
        end
        #1;
    endtask

    task automatic idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
        id_use_rs = 1'b0; id_use_rt = 1'b0; id_use_hilo = 1'b0;
        ex_memread = 3'b000; ex_branch_taken = 1'b0; mdu_busy = 1'b0; exc_req = 1'b0;
    endtask

    task automatic test_reset();
        id_rs = 5'd3; id_use_rs = 1'b1; ex_rt = 5'd3; ex_memread = 3'b001;
        exc_req = 1'b1; mdu_busy = 1'b1; id_use_hilo = 1'b1;
        #1;
        checks++;
        if (outs !== ONone) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b", outs, ONone);
        end
`ifdef PIPE_HAZARD_STATS_EN
        checks++;
        if (stall_count !== 32'd0 || flush_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_counters: got %0d/%0d expected 0/0", stall_count, flush_count);
        end
`endif
        idle_inputs();
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        @(negedge clk);
        checks++;
        if (outs !== ONone) begin
            errors++;
            $display("FAIL reset_release: got %b expected %b", outs, ONone);
        end
        tick();
    endtask

    task automatic test_load_use();
        id_rs = 5'd8; id_use_rs = 1'b1; ex_rt = 5'd8; ex_memread = 3'b001;
        @(negedge clk);
        checks++;
        if (outs !== OStall) begin
            errors++;
            $display("FAIL lu_stall: got %b expected %b", outs, OStall);
        end
        tick();
        @(negedge clk);
        checks++;
        if (outs !== ONone) begin
            errors++;
            $display("FAIL lu_no_double: got %b expected %b", outs, ONone);
        end
        tick();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (outs !== ONone) begin
            errors++;
            $display("FAIL lu_release: got %b expected %b", outs, ONone);
        end
        tick();
    endtask

    task automatic test_zero_reg();
        ex_memread = 3'b001; ex_rt = 5'd0; id_rt = 5'd0; id_use_rt = 1'b1;
        id_rs = 5'd0; id_use_rs = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (outs !== ONone) begin
                errors++;
                $display("FAIL zero_reg cyc %0d: got %b expected %b", i, outs, ONone);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_mdu();
        mdu_busy = 1'b1; id_use_hilo = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (outs !== OStall) begin
                errors++;
                $display("FAIL mdu_stall cyc %0d: got %b expected %b", i, outs, OStall);
            end
            tick();
        end
        mdu_busy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (outs !== ONone) begin
                errors++;
                $display("FAIL mdu_release cyc %0d: got %b expected %b", i, outs, ONone);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_exception();
        logic [5:0] want [4];
        // Single pulse: flush exactly N cycles, MDU stall request ignored meanwhile.
        exc_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (outs !== ((i < N) ? OExc : ONone)) begin
                errors++;
                $display("FAIL exc_pulse cyc %0d: got %b expected %b", i, outs,
                         (i < N) ? OExc : ONone);
            end
            tick();
            exc_req = 1'b0;
            if (i == 0) begin
                mdu_busy = 1'b1; id_use_hilo = 1'b1;
            end else begin
                mdu_busy = 1'b0; id_use_hilo = 1'b0;
            end
        end
        // Second request in the 2nd flush cycle extends by one.
        want[0] = OExc; want[1] = OExc; want[2] = OExc; want[3] = ONone;
        for (int i = 0; i < 4; i++) begin
            exc_req = (i < 2);
            @(negedge clk);
            checks++;
            if (outs !== want[i]) begin
                errors++;
                $display("FAIL exc_extend cyc %0d: got %b expected %b", i, outs, want[i]);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_priority();
        id_rt = 5'd12; id_use_rt = 1'b1; ex_rt = 5'd12; ex_memread = 3'b100;
        ex_branch_taken = 1'b1;
        @(negedge clk);
        checks++;
        if (outs !== OBr) begin
            errors++;
            $display("FAIL prio_branch_over_lu: got %b expected %b", outs, OBr);
        end
        tick();
        // Still in RUN, so the unchanged load-use now stalls.
        ex_branch_taken = 1'b0;
        @(negedge clk);
        checks++;
        if (outs !== OStall) begin
            errors++;
            $display("FAIL prio_state_run: got %b expected %b", outs, OStall);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid_stall();
        mdu_busy = 1'b1; id_use_hilo = 1'b1;
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (outs !== ONone) begin
            errors++;
            $display("FAIL reset_mid_mdu: got %b expected %b", outs, ONone);
        end
`ifdef PIPE_HAZARD_STATS_EN
        checks++;
        if (stall_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_stall_count: got %0d expected 0", stall_count);
        end
`endif
        model_clear();
        tick();
        reset = 1'b0;
        idle_inputs();
        @(negedge clk);
        checks++;
        if (outs !== ONone) begin
            errors++;
            $display("FAIL reset_mid_after: got %b expected %b", outs, ONone);
        end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            id_rs           = 5'($urandom_range(0, 3));
            id_rt           = 5'($urandom_range(0, 3));
            ex_rt           = 5'($urandom_range(0, 3));
            id_use_rs       = 1'($urandom_range(0, 1));
            id_use_rt       = 1'($urandom_range(0, 1));
            id_use_hilo     = ($urandom_range(0, 3) != 0);
            ex_memread      = ($urandom_range(0, 1) != 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            ex_branch_taken = ($urandom_range(0, 9) == 0);
            mdu_busy        = ($urandom_range(0, 2) == 0);
            exc_req         = ($urandom_range(0, 19) == 0);
            @(negedge clk);
            model_eval();
            checks++;
            if (outs !== e) begin
                errors++;
                $display("FAIL random cyc %0d: got %b expected %b", i, outs, e);
            end
            tick();
        end
        idle_inputs();
`ifdef PIPE_HAZARD_STATS_EN
        #1;
        checks++;
        if (stall_count !== m_stall_cnt || flush_count !== m_flush_cnt) begin
            errors++;
            $display("FAIL stats_counts: got %0d/%0d expected %0d/%0d",
                     stall_count, flush_count, m_stall_cnt, m_flush_cnt);
        end
`endif
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        model_clear();
        #12;
        test_reset();
        test_load_use();
        test_zero_reg();
        test_mdu();
        test_exception();
        test_priority();
        test_reset_mid_stall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
